load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core's memory stage and the word-wide data RAM and turns core load/store requests into RAM word accesses. It handles byte, halfword and word accesses, sign/zero-extends loads, and does read-modify-write for sub-word stores. Accesses that cross a word boundary are split into two RAM words. A multi-cycle FSM drives `busy`/`done` to stall the core.

## Interface
Parameters:
- `profundidad`, 1024: RAM depth in 32-bit words. `AW = $clog2(profundidad)`.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request, sampled in IDLE.
- `MemWrite` in 1: store request, sampled in IDLE. Wins over `MemRead` if both are high.
- `funct3` in 3: RV32 size/sign code (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
- `addr` in 32: byte address.
- `store_data` in 32: store value, low bytes used for sub-word stores.
- `load_data` out 32: registered load result.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: illegal `funct3`, pulses together with `done`.
- `ram_address` out AW: RAM word index.
- `ram_write_data` out 32: merged word to write.
- `ram_MemWrite` out 1: RAM write enable.
- `ram_MemRead` out 1: RAM read strobe.
- `ram_read_data` in 32: RAM asynchronous read data.

## Operation
- **Request acceptance:** in IDLE, `MemRead|MemWrite` high accepts a request. `addr`, `funct3`, `store_data` and the direction are captured. While `busy` is high, request inputs are ignored.
- **Address decode:**
  - word index `k = addr[AW+1:2]`, offset `o = addr[1:0]`.
  - size `n` = 1, 2 or 4 bytes from `funct3[1:0]`.
  - upper address bits are ignored, so indices wrap modulo `profundidad`.
- **Split rule:** the access is split when `o + n > 4`. The second word is `(k+1) mod profundidad`, so index `profundidad-1` wraps to 0.
- **Illegal codes:** `funct3` ∈ {011, 110, 111} goes IDLE→DONE. No RAM access, `err`=1, `load_data` unchanged.
- **States:** IDLE, RD0, RD1, WR0, WR1, DONE.
  - **Load:** IDLE→RD0→(RD1 if split)→DONE→IDLE.
  - **Store:** IDLE→RD0→(RD1 if split)→WR0→(WR1 if split)→DONE→IDLE.
- **Word reads:** RD0 and RD1 drive `ram_address` = k or k+1 with `ram_MemRead`=1. `ram_read_data` is captured at the end of the cycle into buffers w0/w1. Only RD0 and RD1 assert `ram_MemRead`.
- **Load result:** little-endian. Take `{w1,w0} >> (8*o)`, keep the low `n` bytes, then:
  - sign-extend if `funct3[2]`=0,
  - zero-extend if `funct3[2]`=1.

  The result is registered into `load_data` on entry to DONE and held until the next completed load.
- **Store merge:** WR0 writes w0 with bytes `o..min(o+n,4)-1` replaced by the low bytes of `store_data`. WR1 writes w1 with the remaining bytes replaced, starting at byte 0. `ram_MemWrite`=1 only in WR0 and WR1.
- **Idle RAM outputs:** outside active states, `ram_MemWrite`=0, `ram_MemRead`=0, `ram_address`=0, `ram_write_data`=0.
- **Reset:**
  - state → IDLE, `load_data`=0, and every output = 0.
  - reset during WR1 leaves the WR0 word committed and the second word unwritten. This partial store is accepted.
  - reset during RD states writes nothing.

## Timing
- Cycle 0 is the request cycle in IDLE.
- Latency:
  - aligned load: `done` in cycle 2.
  - split load: `done` in cycle 3.
  - aligned store: `done` in cycle 3.
  - split store: `done` in cycle 5.
  - illegal code: `done` and `err` in cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after DONE. `done` is high for exactly one cycle, with `busy`=1.
- A new request can be accepted in the cycle following DONE, since IDLE is entered at that edge.
- `ram_read_data` is combinational from `ram_address` and is sampled at the end of RD0/RD1, so there is no extra RAM latency.
- The RAM write lands on the rising edge that ends WR0/WR1.

## Test plan
- **Sign/zero extension:** word 4 = 0x8899AABB.
  - LB at 0x11 → `load_data`=0xFFFFFFAA, `done` in cycle 2.
  - LBU at 0x11 → 0x000000AA.
  - LH at 0x12 → 0xFFFF8899.
- **Split load:** word 4 = 0x8899AABB, word 5 = 0x44332211. LW at 0x13 → 0x33221188, `done` in cycle 3, RAM reads of index 4 then 5.
- **Split store:** word 5 = 0x44332211, word 6 = 0x00000000. SH 0x0000BEEF at 0x17 → word 5 = 0xEF332211, word 6 = 0x000000BE, `done` in cycle 5, exactly two RAM writes.
- **Wrap-around:** LW at byte address 4*profundidad-2 → bytes taken from the last word and word 0, second read at index 0.
- **Illegal code and ignored requests:** `funct3`=011 → `err`=`done`=1 in cycle 1, no RAM strobes, `load_data` unchanged. A request pulsed while `busy` is high is ignored.
- **Reset mid-store:** assert `rst_n`=0 during WR1 of a split SW → state IDLE and all outputs 0 immediately. The first word is updated, the second is unchanged, and no `done` pulse occurs.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/halfword/word core accesses onto a word-wide RAM,
// splitting boundary-crossing accesses and doing read-modify-write for stores.
module load_store_unit #(
    parameter int unsigned profundidad = 1024,
    localparam int unsigned AW = $clog2(profundidad)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [2:0]    funct3,
    input  logic [31:0]   addr,
    input  logic [31:0]   store_data,
    output logic [31:0]   load_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] ram_address,
    output logic [31:0]   ram_write_data,
    output logic          ram_MemWrite,
    output logic          ram_MemRead,
    input  logic [31:0]   ram_read_data
);

    typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr0, StWr1, StDone} state_t;

    localparam logic [AW-1:0] LastIdx = AW'(profundidad - 1);

    state_t        state_q, state_d;
    logic          write_q, err_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [AW-1:0] idx_q, idx_nxt;
    logic [31:0]   sdata_q, w0_q, w1_q, load_data_q;

    logic          accept, illegal, split, load_upd;
    logic [2:0]    size_n;
    logic [7:0]    bmask;
    logic [63:0]   mask64, sst64, merged, rd_pair, shifted;
    logic [31:0]   load_ext;
    logic          unused_addr;

    assign unused_addr = ^addr[31:AW+2];

    assign accept  = (state_q == StIdle) && (MemRead || MemWrite);
    assign illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    assign idx_nxt = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

    always_comb begin
        size_n = 3'd4;
        bmask  = 8'b0000_1111;
        unique case (f3_q[1:0])
            2'b00:   begin size_n = 3'd1; bmask = 8'b0000_0001; end
            2'b01:   begin size_n = 3'd2; bmask = 8'b0000_0011; end
            default: begin size_n = 3'd4; bmask = 8'b0000_1111; end
        endcase
    end

    assign split = ({1'b0, off_q} + size_n) > 3'd4;

    // Store merge over the two-word window {w1, w0}; store bytes land at offset o.
    always_comb begin
        mask64 = '0;
        for (int i = 0; i < 8; i++) begin
            mask64[8*i +: 8] = {8{bmask[i]}} << 0;
        end
        mask64 = mask64 << {off_q, 3'b000};
        sst64  = {32'b0, sdata_q} << {off_q, 3'b000};
        merged = ({w1_q, w0_q} & ~mask64) | (sst64 & mask64);
    end

    // In RD1 the second word is still on the RAM bus; in RD0 only the first is.
    assign rd_pair = (state_q == StRd1) ? {ram_read_data, w0_q} : {32'b0, ram_read_data};
    assign shifted = rd_pair >> {off_q, 3'b000};

    always_comb begin
        unique case (f3_q[1:0])
            2'b00:   load_ext = f3_q[2] ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = f3_q[2] ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted[31:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = illegal ? StDone : StRd0;
            StRd0:   state_d = split ? StRd1 : (write_q ? StWr0 : StDone);
            StRd1:   state_d = write_q ? StWr0 : StDone;
            StWr0:   state_d = split ? StWr1 : StDone;
            StWr1:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign load_upd = !write_q && (state_d == StDone) &&
                      ((state_q == StRd0) || (state_q == StRd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            f3_q        <= 3'b0;
            off_q       <= 2'b0;
            idx_q       <= '0;
            sdata_q     <= 32'b0;
            w0_q        <= 32'b0;
            w1_q        <= 32'b0;
            load_data_q <= 32'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= MemWrite;
                err_q   <= illegal;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                idx_q   <= addr[AW+1:2];
                sdata_q <= store_data;
            end
            if (state_q == StRd0) w0_q <= ram_read_data;
            if (state_q == StRd1) w1_q <= ram_read_data;
            if (load_upd) load_data_q <= load_ext;
        end
    end

    always_comb begin
        ram_address    = '0;
        ram_write_data = 32'b0;
        ram_MemWrite   = 1'b0;
        ram_MemRead    = 1'b0;
        unique case (state_q)
            StRd0: begin ram_MemRead = 1'b1; ram_address = idx_q; end
            StRd1: begin ram_MemRead = 1'b1; ram_address = idx_nxt; end
            StWr0: begin
                ram_MemWrite   = 1'b1;
                ram_address    = idx_q;
                ram_write_data = merged[31:0];
            end
            StWr1: begin
                ram_MemWrite   = 1'b1;
                ram_address    = idx_nxt;
                ram_write_data = merged[63:32];
            end
            default: ;
        endcase
    end

    assign load_data = load_data_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = done && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word RAM.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'b0, store_data = 32'b0;
    logic [31:0] load_data, ram_write_data, ram_read_data;
    logic        busy, done, err, ram_MemWrite, ram_MemRead;
    logic [9:0]  ram_address;

    logic [31:0] mem [1024];
    logic        pk_en = 1'b0;
    logic [9:0]  pk_idx = '0;
    logic [31:0] pk_val = '0;

    int tests = 0;
    int fails = 0;
    logic [9:0] rd_q [$];
    int wr_cnt;
    int dcyc;
    logic eseen;
    logic saw_done;

    always #5 clk = ~clk;

    load_store_unit #(.profundidad(1024)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .addr(addr), .store_data(store_data), .load_data(load_data),
        .busy(busy), .done(done), .err(err), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_MemWrite(ram_MemWrite),
        .ram_MemRead(ram_MemRead), .ram_read_data(ram_read_data)
    );

    assign ram_read_data = mem[ram_address];

    always @(posedge clk) begin
        if (ram_MemWrite) mem[ram_address] <= ram_write_data;
        else if (pk_en) mem[pk_idx] <= pk_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] idx, input logic [31:0] val);
        pk_en = 1'b1; pk_idx = idx; pk_val = val;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    // Issues one request at a negedge (cycle 0) and returns at the done cycle's negedge.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          output int dc, output logic es);
        rd_q.delete();
        wr_cnt = 0;
        dc = -1;
        es = 1'b0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; store_data = sd;
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (ram_MemRead) rd_q.push_back(ram_address);
            if (ram_MemWrite) wr_cnt++;
            if (done) begin
                dc = c;
                es = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rdq(input int i);
        return (rd_q.size() > i) ? 32'(rd_q[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        @(negedge clk);
        poke(10'd4, 32'h8899AABB);
        poke(10'd5, 32'h44332211);
        poke(10'd6, 32'h00000000);
        poke(10'd7, 32'h11111111);
        poke(10'd8, 32'h22222222);
        poke(10'd1023, 32'hA1B2C3D4);
        poke(10'd0, 32'h55667788);

        chk("rst_load_data", load_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done_err", {30'b0, done, err}, 32'h0);
        chk("rst_ram_strobes", {30'b0, ram_MemRead, ram_MemWrite}, 32'h0);
        chk("rst_ram_addr", 32'(ram_address), 32'h0);
        rst_n = 1'b1;

        run_op(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, dcyc, eseen);
        chk("lb_data", load_data, 32'hFFFFFFAA);
        chk("lb_cycle", 32'(dcyc), 32'd2);
        chk("lb_busy_at_done", 32'(busy), 32'h1);
        chk("lb_reads", 32'(rd_q.size()), 32'd1);
        chk("lb_read_idx", rdq(0), 32'd4);

        run_op(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, dcyc, eseen);
        chk("lbu_data", load_data, 32'h000000AA);

        run_op(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, dcyc, eseen);
        chk("lh_data", load_data, 32'hFFFF8899);
        chk("lh_cycle", 32'(dcyc), 32'd2);

        run_op(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, dcyc, eseen);
        chk("lw_split_data", load_data, 32'h33221188);
        chk("lw_split_cycle", 32'(dcyc), 32'd3);
        chk("lw_split_rd0", rdq(0), 32'd4);
        chk("lw_split_rd1", rdq(1), 32'd5);

        run_op(1'b0, 1'b1, 3'b001, 32'h17, 32'h0000BEEF, dcyc, eseen);
        chk("sh_split_cycle", 32'(dcyc), 32'd5);
        chk("sh_split_writes", 32'(wr_cnt), 32'd2);
        chk("sh_split_w5", mem[5], 32'hEF332211);
        chk("sh_split_w6", mem[6], 32'h000000BE);
        chk("sh_keeps_load_data", load_data, 32'h33221188);

        run_op(1'b0, 1'b1, 3'b000, 32'h19, 32'h123456CD, dcyc, eseen);
        chk("sb_cycle", 32'(dcyc), 32'd3);
        chk("sb_writes", 32'(wr_cnt), 32'd1);
        chk("sb_w6", mem[6], 32'h0000CDBE);

        run_op(1'b1, 1'b0, 3'b010, 32'd4094, 32'h0, dcyc, eseen);
        chk("wrap_data", load_data, 32'h7788A1B2);
        chk("wrap_rd0", rdq(0), 32'd1023);
        chk("wrap_rd1", rdq(1), 32'd0);
        chk("wrap_cycle", 32'(dcyc), 32'd3);

        run_op(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, dcyc, eseen);
        chk("illegal_cycle", 32'(dcyc), 32'd1);
        chk("illegal_err", 32'(eseen), 32'h1);
        chk("illegal_no_ram", 32'(rd_q.size() + wr_cnt), 32'd0);
        chk("illegal_load_data", load_data, 32'h7788A1B2);

        // Aligned LW at 0x10 with a store held high while busy; the store must be dropped.
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'b010; addr = 32'h10;
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; addr = 32'h14; store_data = 32'hFFFFFFFF;
        chk("busy_cycle1", {30'b0, busy, done}, 32'h2);
        @(negedge clk);
        chk("ign_done_cycle2", 32'(done), 32'h1);
        chk("ign_err_low", 32'(err), 32'h0);
        chk("ign_lw_data", load_data, 32'h8899AABB);
        MemWrite = 1'b0;
        @(negedge clk);
        chk("ign_idle_after_done", 32'(busy), 32'h0);
        @(negedge clk);
        chk("ign_still_idle", 32'(busy), 32'h0);
        chk("ign_w5_unchanged", mem[5], 32'hEF332211);

        // Split SW at 0x1E; reset lands in WR1 (cycle 4).
        saw_done = 1'b0;
        MemWrite = 1'b1; funct3 = 3'b010; addr = 32'h1E; store_data = 32'hAABBCCDD;
        @(negedge clk);
        MemWrite = 1'b0;
        for (int c = 1; c < 4; c++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        if (done) saw_done = 1'b1;
        chk("rstwr_in_wr1", {ram_MemWrite, 21'b0, ram_address}, {1'b1, 21'b0, 10'd8});
        rst_n = 1'b0;
        #1;
        chk("rstwr_busy", 32'(busy), 32'h0);
        chk("rstwr_outputs", {ram_MemWrite, ram_MemRead, done, err, ram_address, 18'b0},
            32'h0);
        chk("rstwr_wdata", ram_write_data, 32'h0);
        chk("rstwr_load_data", load_data, 32'h0);
        @(negedge clk);
        chk("rstwr_no_done", 32'(saw_done || done), 32'h0);
        chk("rstwr_w7", mem[7], 32'hCCDD1111);
        chk("rstwr_w8", mem[8], 32'h22222222);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
